// File: rtl/stride_addr_gen.sv
// ============================================================================
// stride_addr_gen
// ----------------------------------------------------------------------------
// Burst address generator. A burst request loads a base address and a beat
// count. The block then presents one address per beat on a valid/ready
// handshake. Each address is the previous one plus 2^STEP_LSB, where
// STEP_LSB = 1 << POWER_OF_2. Address bits below STEP_LSB pass through
// unchanged. The field above them counts up modulo 2^(WIDTH-STEP_LSB).
//
// Parameters
//   WIDTH       address width (default 8)
//   POWER_OF_2  step select; step = 2^(2^POWER_OF_2) (default 0 -> step 2)
//               The parameter must give STEP_LSB < WIDTH.
//   LEN_W       beat-count width; the longest burst is 2^LEN_W - 1 beats
//
// Ports
//   clk_i    in   clock; all state changes on the rising edge
//   rst_i    in   synchronous active-high reset
//   start_i  in   burst request; sampled only while idle
//   base_i   in   first address of the burst; sampled with start_i
//   len_i    in   beat count of the burst; sampled with start_i
//   busy_o   out  high while a burst is running
//   addr_o   out  current address (registered)
//   valid_o  out  addr_o is valid
//   ready_i  in   downstream accepts addr_o
//   last_o   out  the current beat is the final beat of the burst
//   done_o   out  one-cycle pulse after the final handshake of a burst
//   err_o    out  one-cycle pulse when a burst is aborted on address overflow
//
// Optional feature
//   STRIDE_ADDR_GEN_WRAP_ERR_EN
//     Undefined: the address wraps silently past the top of the space, and
//                err_o is tied low.
//     Defined:   a beat that would wrap the upper address field aborts the
//                burst. The block returns to idle, pulses err_o, and drops
//                the remaining beats without a done_o.
// ============================================================================
module stride_addr_gen #(
    parameter int WIDTH      = 8,
    parameter int POWER_OF_2 = 0,
    parameter int LEN_W      = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] base_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic [WIDTH-1:0] addr_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             last_o,
    output logic             done_o,
    output logic             err_o
);

    // Bit position of the step and width of the counting field above it
    localparam int STEP_LSB = 1 << POWER_OF_2;
    localparam int UP_W     = WIDTH - STEP_LSB;

    // Sequencer states
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic             r_state;
    logic [WIDTH-1:0] r_addr;
    logic [LEN_W-1:0] r_rem;
    logic             r_valid;
    logic             r_last;
    logic             r_done;

    logic [UP_W-1:0]  w_upper;
    logic [UP_W-1:0]  w_upperInc;
    logic [WIDTH-1:0] w_addrInc;
    logic             w_handshake;
    logic             w_remIsOne;
    logic             w_remIsTwo;

`ifdef STRIDE_ADDR_GEN_WRAP_ERR_EN
    logic             r_err;
    logic             w_upperAllOnes;
`endif

    // Incrementer. The field above the step position counts up by one, and
    // a carry past the top of the field is dropped. This gives the wrapping
    // behaviour. It also matches the rule "bit i toggles when every bit from
    // STEP_LSB up to i-1 is 1". The low bits are copied through so that an
    // unaligned base keeps its offset inside each stride.
    always_comb begin
        w_upper    = r_addr[WIDTH-1:STEP_LSB];
        w_upperInc = w_upper + UP_W'(1);
        w_addrInc  = {w_upperInc, r_addr[STEP_LSB-1:0]};
    end

    // Handshake and remaining-beat decode. These use only registered state
    // plus ready_i, and they only feed the next-state logic. So no output
    // depends combinationally on ready_i.
    always_comb begin
        w_handshake = r_valid & ready_i;
        w_remIsOne  = (r_rem == LEN_W'(1));
        w_remIsTwo  = (r_rem == LEN_W'(2));
    end

`ifdef STRIDE_ADDR_GEN_WRAP_ERR_EN
    // The next increment would carry out of the upper field. This happens
    // when every bit above the step position is already set.
    always_comb begin
        w_upperAllOnes = &r_addr[WIDTH-1:STEP_LSB];
    end
`endif

    // Main sequencer.
    //
    // In IDLE, a start with a non-zero length loads the burst. The first
    // address shows up on the very next cycle. A start with zero length
    // emits no beats and only pulses done_o.
    //
    // In RUN, the address, last flag and beat count hold until a handshake.
    // A handshake on the final beat ends the burst with a done_o pulse.
    // Any other handshake advances to the next address.
    //
    // last_o is kept as its own register. It is set when exactly one beat
    // remains after the update, so it lines up with the final address
    // without decoding the counter at the output.
    //
    // done_o and err_o default to low every cycle, so each is a
    // single-cycle pulse. A reset in the middle of a burst clears
    // everything, and the burst emits no pulse at all.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_rem   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
`ifdef STRIDE_ADDR_GEN_WRAP_ERR_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef STRIDE_ADDR_GEN_WRAP_ERR_EN
            r_err  <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            r_state <= ST_RUN;
                            r_addr  <= base_i;
                            r_rem   <= len_i;
                            r_valid <= 1'b1;
                            r_last  <= (len_i == LEN_W'(1));
                        end else begin
                            r_done  <= 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    if (w_handshake) begin
                        if (w_remIsOne) begin
                            r_state <= ST_IDLE;
                            r_rem   <= '0;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_done  <= 1'b1;
`ifdef STRIDE_ADDR_GEN_WRAP_ERR_EN
                        end else if (w_upperAllOnes) begin
                            r_state <= ST_IDLE;
                            r_rem   <= '0;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_err   <= 1'b1;
`endif
                        end else begin
                            r_rem   <= r_rem - LEN_W'(1);
                            r_addr  <= w_addrInc;
                            r_last  <= w_remIsTwo;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                end
            endcase
        end
    end

    // Output mapping. Every output comes straight from a register.
    always_comb begin
        busy_o  = (r_state == ST_RUN);
        addr_o  = r_addr;
        valid_o = r_valid;
        last_o  = r_last;
        done_o  = r_done;
`ifdef STRIDE_ADDR_GEN_WRAP_ERR_EN
        err_o   = r_err;
`else
        err_o   = 1'b0;
`endif
    end

endmodule
